// File: rtl/alu_decode_stage.sv
// ID->EX register for ALU32Bit control. It decodes a MIPS instruction into ALU op, operand selects,
// enables and the extended immediate, and supports valid, stall and flush.
module alu_decode_stage (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic [31:0] Instruction,
    input  logic        InValid,
    input  logic        Stall,
    input  logic        Flush,
    output logic        OutValid,
    output logic [4:0]  ALUControl,
    output logic [5:0]  Opcode,
    output logic        ASel,
    output logic [4:0]  Shamt,
    output logic        ALUSrcB,
    output logic [31:0] Imm,
    output logic        RegDst,
    output logic        RegWrite,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        Illegal
);

    typedef struct packed {
        logic        valid;
        logic [4:0]  alu_ctl;
        logic [5:0]  opcode;
        logic        asel;
        logic [4:0]  shamt;
        logic        srcb;
        logic [31:0] imm;
        logic        regdst;
        logic        regwrite;
        logic        memread;
        logic        memwrite;
        logic        illegal;
    } bundle_t;

    bundle_t bundle_q, bundle_d, dec;

    logic [5:0] op, funct;
    logic [4:0] sa;
    logic       rfmt, is_jr;
    logic       unused_rs_rt;

    assign op    = Instruction[31:26];
    assign funct = Instruction[5:0];
    assign sa    = Instruction[10:6];
    assign unused_rs_rt = ^{Instruction[25:22], Instruction[20:16]};

    always_comb begin
        dec          = '0;
        dec.valid    = 1'b1;
        dec.opcode   = op;
        dec.shamt    = sa;
        dec.alu_ctl  = 5'b11111;
        rfmt         = 1'b0;
        is_jr        = 1'b0;
        // andi/ori/xori/lui (001100..001111) take a zero-extended immediate
        dec.imm = (op[5:2] == 4'b0011) ? {16'h0000, Instruction[15:0]}
                                       : {{16{Instruction[15]}}, Instruction[15:0]};
        case (op)
            6'b000000: begin
                rfmt = 1'b1;
                case (funct)
                    6'b100000, 6'b100001: dec.alu_ctl = 5'b00000;
                    6'b100010: dec.alu_ctl = 5'b00001;
                    6'b100100: dec.alu_ctl = 5'b00011;
                    6'b100101: dec.alu_ctl = 5'b00100;
                    6'b100111: dec.alu_ctl = 5'b00101;
                    6'b100110: dec.alu_ctl = 5'b00110;
                    6'b101010: dec.alu_ctl = 5'b01010;
                    6'b101011: dec.alu_ctl = 5'b01110;
                    6'b000000: begin dec.alu_ctl = 5'b00111; dec.asel = 1'b1; end
                    6'b000100: dec.alu_ctl = 5'b00111;
                    6'b000010: begin
                        dec.alu_ctl = Instruction[21] ? 5'b01001 : 5'b01000;
                        dec.asel    = 1'b1;
                    end
                    6'b000110: dec.alu_ctl = Instruction[6] ? 5'b01001 : 5'b01000;
                    6'b000011: begin dec.alu_ctl = 5'b01101; dec.asel = 1'b1; end
                    6'b000111: dec.alu_ctl = 5'b01101;
                    6'b001000: begin dec.alu_ctl = 5'b11111; is_jr = 1'b1; end
                    default:   dec.illegal = 1'b1;
                endcase
            end
            6'b011100: begin
                rfmt = 1'b1;
                if (funct == 6'b000010) dec.alu_ctl = 5'b10011;
                else                    dec.illegal = 1'b1;
            end
            6'b011111: begin
                rfmt = 1'b1;
                if (funct == 6'b100000 && sa == 5'b11000)      dec.alu_ctl = 5'b10110;
                else if (funct == 6'b100000 && sa == 5'b10000) dec.alu_ctl = 5'b10111;
                else                                           dec.illegal = 1'b1;
            end
            6'b001000, 6'b001001, 6'b001010, 6'b001011,
            6'b001100, 6'b001101, 6'b001110, 6'b001111: begin
                dec.alu_ctl  = 5'b00000;
                dec.srcb     = 1'b1;
                dec.regwrite = 1'b1;
            end
            6'b100011, 6'b100001, 6'b100000: begin
                dec.alu_ctl  = 5'b00000;
                dec.srcb     = 1'b1;
                dec.regwrite = 1'b1;
                dec.memread  = 1'b1;
            end
            6'b101011, 6'b101001, 6'b101000: begin
                dec.alu_ctl  = 5'b00000;
                dec.srcb     = 1'b1;
                dec.memwrite = 1'b1;
            end
            6'b000010, 6'b000011: dec.alu_ctl = 5'b11111;
            default: dec.illegal = 1'b1;
        endcase
        if (rfmt) begin
            dec.regdst   = 1'b1;
            dec.regwrite = ~is_jr;
        end
        // Illegal words keep only the raw field copies; every control is cleared
        if (dec.illegal) begin
            dec.alu_ctl  = 5'b11111;
            dec.asel     = 1'b0;
            dec.srcb     = 1'b0;
            dec.regdst   = 1'b0;
            dec.regwrite = 1'b0;
            dec.memread  = 1'b0;
            dec.memwrite = 1'b0;
        end
    end

    always_comb begin
        bundle_d = bundle_q;
        if (Flush)        bundle_d = '0;
        else if (!Stall)  bundle_d = InValid ? dec : '0;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) bundle_q <= '0;
        else        bundle_q <= bundle_d;
    end

    assign OutValid   = bundle_q.valid;
    assign ALUControl = bundle_q.alu_ctl;
    assign Opcode     = bundle_q.opcode;
    assign ASel       = bundle_q.asel;
    assign Shamt      = bundle_q.shamt;
    assign ALUSrcB    = bundle_q.srcb;
    assign Imm        = bundle_q.imm;
    assign RegDst     = bundle_q.regdst;
    assign RegWrite   = bundle_q.regwrite;
    assign MemRead    = bundle_q.memread;
    assign MemWrite   = bundle_q.memwrite;
    assign Illegal    = bundle_q.illegal;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Bench for alu_decode_stage: directed vectors, a table-driven reference decoder checked on every
// falling edge, and hand-computed literal expectations.
module tb_alu_decode_stage;

    typedef struct packed {
        logic        ov;
        logic [4:0]  ctl;
        logic [5:0]  op;
        logic        asel;
        logic [4:0]  sh;
        logic        srcb;
        logic [31:0] imm;
        logic        rd;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        ill;
    } out_t;

    typedef struct {
        logic [31:0] mask;
        logic [31:0] match;
        logic [4:0]  ctl;
        logic        asel;
        int          kind;
    } rule_t;

    localparam int K_R = 0, K_JR = 1, K_I = 2, K_L = 3, K_S = 4, K_J = 5;

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic [31:0] Instruction = '0;
    logic        InValid = 1'b0, Stall = 1'b0, Flush = 1'b0;
    logic        OutValid, ASel, ALUSrcB, RegDst, RegWrite, MemRead, MemWrite, Illegal;
    logic [4:0]  ALUControl, Shamt;
    logic [5:0]  Opcode;
    logic [31:0] Imm;

    int   vectors = 0;
    int   miscompares = 0;
    logic cmp_en = 1'b0;
    out_t act;
    out_t exp_q = '0;
    rule_t rules[$];

    alu_decode_stage dut (
        .Clk(Clk), .Rst_n(Rst_n), .Instruction(Instruction), .InValid(InValid),
        .Stall(Stall), .Flush(Flush), .OutValid(OutValid), .ALUControl(ALUControl),
        .Opcode(Opcode), .ASel(ASel), .Shamt(Shamt), .ALUSrcB(ALUSrcB), .Imm(Imm),
        .RegDst(RegDst), .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite),
        .Illegal(Illegal)
    );

    assign act = {OutValid, ALUControl, Opcode, ASel, Shamt, ALUSrcB, Imm,
                  RegDst, RegWrite, MemRead, MemWrite, Illegal};

    always #5 Clk = ~Clk;

    task automatic add_rule(input logic [31:0] mask, input logic [31:0] match,
                            input logic [4:0] ctl, input logic asel, input int kind);
        rule_t r;
        r.mask = mask; r.match = match; r.ctl = ctl; r.asel = asel; r.kind = kind;
        rules.push_back(r);
    endtask

    function automatic out_t model(input logic [31:0] ins);
        out_t o = '0;
        int   hit = -1;
        foreach (rules[i])
            if (hit < 0 && (ins & rules[i].mask) == rules[i].match) hit = i;
        o.ov  = 1'b1;
        o.op  = ins[31:26];
        o.sh  = ins[10:6];
        o.imm = (ins[31:26] inside {6'h0C, 6'h0D, 6'h0E, 6'h0F}) ? {16'h0, ins[15:0]}
                                                                 : {{16{ins[15]}}, ins[15:0]};
        if (hit < 0) begin
            o.ctl = 5'h1F;
            o.ill = 1'b1;
            return o;
        end
        o.ctl  = rules[hit].ctl;
        o.asel = rules[hit].asel;
        case (rules[hit].kind)
            K_R:  begin o.rd = 1'b1; o.rw = 1'b1; end
            K_JR: o.rd = 1'b1;
            K_I:  begin o.srcb = 1'b1; o.rw = 1'b1; end
            K_L:  begin o.srcb = 1'b1; o.rw = 1'b1; o.mr = 1'b1; end
            K_S:  begin o.srcb = 1'b1; o.mw = 1'b1; end
            default: ;
        endcase
        return o;
    endfunction

    always @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n)       exp_q <= '0;
        else if (Flush)   exp_q <= '0;
        else if (!Stall)  exp_q <= InValid ? model(Instruction) : '0;
    end

    always @(negedge Clk) begin
        if (cmp_en) begin
            vectors++;
            if (act !== exp_q) begin
                miscompares++;
                $display("FAIL model-compare t=%0t got %h want %h", $time, act, exp_q);
            end
        end
    end

    task automatic pin(input string name, input logic [63:0] got, input logic [63:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    task automatic step(input logic [31:0] ins, input logic v, input logic s, input logic f);
        Instruction = ins; InValid = v; Stall = s; Flush = f;
        @(posedge Clk);
        #1;
    endtask

    initial begin
        logic [31:0] extra[$];
        // R-format rows key on opcode+funct; shifts also key on the rotate bit
        add_rule(32'hFC00003F, 32'h00000020, 5'b00000, 1'b0, K_R);
        add_rule(32'hFC00003F, 32'h00000021, 5'b00000, 1'b0, K_R);
        add_rule(32'hFC00003F, 32'h00000022, 5'b00001, 1'b0, K_R);
        add_rule(32'hFC00003F, 32'h00000024, 5'b00011, 1'b0, K_R);
        add_rule(32'hFC00003F, 32'h00000025, 5'b00100, 1'b0, K_R);
        add_rule(32'hFC00003F, 32'h00000027, 5'b00101, 1'b0, K_R);
        add_rule(32'hFC00003F, 32'h00000026, 5'b00110, 1'b0, K_R);
        add_rule(32'hFC00003F, 32'h0000002A, 5'b01010, 1'b0, K_R);
        add_rule(32'hFC00003F, 32'h0000002B, 5'b01110, 1'b0, K_R);
        add_rule(32'hFC00003F, 32'h00000000, 5'b00111, 1'b1, K_R);
        add_rule(32'hFC00003F, 32'h00000004, 5'b00111, 1'b0, K_R);
        add_rule(32'hFC20003F, 32'h00000002, 5'b01000, 1'b1, K_R);
        add_rule(32'hFC20003F, 32'h00200002, 5'b01001, 1'b1, K_R);
        add_rule(32'hFC00007F, 32'h00000006, 5'b01000, 1'b0, K_R);
        add_rule(32'hFC00007F, 32'h00000046, 5'b01001, 1'b0, K_R);
        add_rule(32'hFC00003F, 32'h00000003, 5'b01101, 1'b1, K_R);
        add_rule(32'hFC00003F, 32'h00000007, 5'b01101, 1'b0, K_R);
        add_rule(32'hFC00003F, 32'h00000008, 5'b11111, 1'b0, K_JR);
        add_rule(32'hFC00003F, 32'h70000002, 5'b10011, 1'b0, K_R);
        add_rule(32'hFC0007FF, 32'h7C000620, 5'b10110, 1'b0, K_R);
        add_rule(32'hFC0007FF, 32'h7C000420, 5'b10111, 1'b0, K_R);
        for (int unsigned o = 6'h08; o <= 6'h0F; o++)
            add_rule(32'hFC000000, o << 26, 5'b00000, 1'b0, K_I);
        foreach (extra[i]) ;
        add_rule(32'hFC000000, 32'h8C000000, 5'b00000, 1'b0, K_L);
        add_rule(32'hFC000000, 32'h84000000, 5'b00000, 1'b0, K_L);
        add_rule(32'hFC000000, 32'h80000000, 5'b00000, 1'b0, K_L);
        add_rule(32'hFC000000, 32'hAC000000, 5'b00000, 1'b0, K_S);
        add_rule(32'hFC000000, 32'hA4000000, 5'b00000, 1'b0, K_S);
        add_rule(32'hFC000000, 32'hA0000000, 5'b00000, 1'b0, K_S);
        add_rule(32'hFC000000, 32'h08000000, 5'b11111, 1'b0, K_J);
        add_rule(32'hFC000000, 32'h0C000000, 5'b11111, 1'b0, K_J);

        repeat (2) @(posedge Clk);
        #1;
        cmp_en = 1'b1;
        pin("reset-all-zero", 64'(act), 64'd0);
        Rst_n = 1'b1;

        step(32'h00221820, 1, 0, 0);
        pin("add-ctl", 64'(ALUControl), 64'h00);
        pin("add-enables", 64'({OutValid, RegWrite, RegDst, ALUSrcB}), 64'b1110);
        step(32'h2022FFFF, 1, 0, 0);
        pin("addi-imm", 64'(Imm), 64'hFFFFFFFF);
        pin("addi-srcb-rd", 64'({ALUSrcB, RegDst}), 64'b10);
        step(32'h3022FFFF, 1, 0, 0);
        pin("andi-imm", 64'(Imm), 64'h0000FFFF);
        step(32'h00221902, 1, 0, 0);
        pin("rotr", 64'({ALUControl, ASel, Shamt}), 64'({5'b01001, 1'b1, 5'd4}));
        step(32'h00021902, 1, 0, 0);
        pin("srl-ctl", 64'(ALUControl), 64'b01000);
        step(32'hAC220004, 1, 0, 0);
        pin("sw", 64'({MemWrite, RegWrite, Imm}), 64'({1'b1, 1'b0, 32'd4}));
        step(32'hFC000000, 1, 0, 0);
        pin("illegal", 64'({OutValid, Illegal, ALUControl, RegWrite, MemRead, MemWrite}),
            64'({1'b1, 1'b1, 5'b11111, 3'b000}));

        step(32'h00221820, 1, 0, 0);
        for (int unsigned i = 0; i < 3; i++) begin
            step(32'hAC220004, 1, 1, 0);
            pin("stall-hold", 64'({ALUControl, RegWrite, MemWrite, RegDst}), 64'({5'b0, 3'b101}));
        end
        step(32'hAC220004, 1, 1, 1);
        pin("stall+flush-bubble", 64'(act), 64'd0);

        extra = '{32'h00000000, 32'h00221823, 32'h00221822, 32'h00221824, 32'h00221825,
                  32'h00221827, 32'h00221826, 32'h0022182A, 32'h0022182B, 32'h00221804,
                  32'h00221846, 32'h00221806, 32'h000218C3, 32'h00221807, 32'h03E00008,
                  32'h70221802, 32'h7C020E20, 32'h7C020C20, 32'h7C020820, 32'h8C220010,
                  32'h84228000, 32'h80220001, 32'hA0220001, 32'hA4220002, 32'h08000010,
                  32'h0C000010, 32'h3C021234, 32'h3422FFFF, 32'h3822FFFF, 32'h2822FFFF,
                  32'h2C228000, 32'h2422FFF0, 32'h70221803, 32'h10220004, 32'h00221821};
        foreach (extra[i]) step(extra[i], 1, 0, 0);
        pin("addu-after-table", 64'({ALUControl, RegWrite}), 64'({5'b0, 1'b1}));

        step(32'h3C021234, 1, 0, 0);
        pin("lui-imm", 64'(Imm), 64'h00001234);
        step(32'h70221802, 1, 0, 0);
        pin("mul-ctl", 64'(ALUControl), 64'b10011);
        step(32'h03E00008, 1, 0, 0);
        pin("jr", 64'({ALUControl, RegWrite, Illegal}), 64'({5'b11111, 2'b00}));
        step(32'h00221820, 0, 0, 0);
        pin("invalid-bubble", 64'(act), 64'd0);
        step(32'h00221820, 1, 0, 0);
        step(32'h00221820, 1, 0, 1);
        pin("flush-bubble", 64'(act), 64'd0);

        step(32'h00221820, 1, 0, 0);
        step(32'hAC220004, 1, 1, 0);
        Rst_n = 1'b0;
        #2;
        pin("async-reset", 64'(act), 64'd0);
        @(posedge Clk);
        #1;
        Rst_n = 1'b1;
        step(32'h8C220010, 1, 0, 0);
        pin("lw-after-reset", 64'({OutValid, MemRead, RegWrite}), 64'b111);
        step(32'h00000000, 0, 0, 0);
        @(negedge Clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
